// File: rtl/trace_replay_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trace_replay_pkg
// Function : Opcode encoding shared by the trace replay node and its helpers.
// Revision : 1.0
// ============================================================================
package trace_replay_pkg;

  localparam int OPCODE_WIDTH = 4;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOP      = 4'd0,
    OP_SEND     = 4'd1,
    OP_RECV     = 4'd2,
    OP_DONE     = 4'd3,
    OP_FINISH   = 4'd4,
    OP_CYC_INIT = 4'd5,
    OP_CYC_WAIT = 4'd6
  } opcode_e;

endpackage
`default_nettype wire

// File: rtl/trace_replay_cycle_ctr.sv
`default_nettype none
// ============================================================================
// Module   : trace_replay_cycle_ctr
// Function : 32-bit loadable down-counter with zero flag for timed waits.
// Revision : 1.0
// ============================================================================
module trace_replay_cycle_ctr (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic        dec_i,
  input  logic [31:0] load_val_i,
  output logic        zero_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 32'd0)) begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 32'd0);

endmodule
`default_nettype wire

// File: rtl/trace_replay_node.sv
`default_nettype none
// ============================================================================
// Module   : trace_replay_node
// Function : ROM-driven stimulus/checker node (valid/yumi out, valid/ready in).
//            Optional debug prints and FINISH->$finish under TRACE_REPLAY_DEBUG_EN.
// Revision : 1.0
// ============================================================================
module trace_replay_node
  import trace_replay_pkg::*;
#(
  parameter int ring_width_p     = 80,
  parameter int rom_addr_width_p = 6
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          en_i,
  input  logic                          v_i,
  input  logic [ring_width_p-1:0]       data_i,
  output logic                          ready_o,
  output logic                          v_o,
  output logic [ring_width_p-1:0]       data_o,
  input  logic                          yumi_i,
  output logic [rom_addr_width_p-1:0]   rom_addr_o,
  input  logic [ring_width_p+3:0]       rom_data_i,
  output logic                          done_o,
  output logic                          error_o
);

  logic [rom_addr_width_p-1:0] addr_q, addr_d;
  logic                        done_q, done_d;
  logic                        error_q, error_d;
  logic [OPCODE_WIDTH-1:0]     opcode;
  logic [ring_width_p-1:0]     payload;
  logic                        active;
  logic                        advance;
  logic                        ctr_load, ctr_dec, ctr_zero;
  logic [31:0]                 cyc_init_val;

  assign opcode  = rom_data_i[ring_width_p+OPCODE_WIDTH-1:ring_width_p];
  assign payload = rom_data_i[ring_width_p-1:0];

  // Reset is folded in so the handshake outputs are low while reset is held.
  assign active  = reset_i & en_i & ~done_q;
  assign v_o     = active & (opcode == OP_SEND);
  assign ready_o = active & (opcode == OP_RECV);
  assign data_o  = v_o ? payload : '0;

  assign rom_addr_o = addr_q;
  assign done_o     = done_q;
  assign error_o    = error_q;

  generate
    if (ring_width_p >= 32) begin : g_init_trunc
      assign cyc_init_val = payload[31:0];
    end else begin : g_init_ext
      assign cyc_init_val = {{(32-ring_width_p){1'b0}}, payload};
    end
  endgenerate

  always_comb begin
    advance  = 1'b0;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    done_d   = done_q;
    error_d  = error_q;
    if (active) begin
      case (opcode)
        OP_NOP:  advance = 1'b1;
        OP_SEND: advance = yumi_i;
        OP_RECV: begin
          if (v_i) begin
            advance = 1'b1;
            if (data_i != payload) error_d = 1'b1;
          end
        end
        OP_DONE, OP_FINISH: done_d = 1'b1;
        OP_CYC_INIT: begin
          ctr_load = 1'b1;
          advance  = 1'b1;
        end
        OP_CYC_WAIT: begin
          if (ctr_zero) advance = 1'b1;
          else          ctr_dec = 1'b1;
        end
        default: begin
          error_d = 1'b1;
          advance = 1'b1;
        end
      endcase
    end
    addr_d = advance ? addr_q + rom_addr_width_p'(1) : addr_q;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      addr_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  trace_replay_cycle_ctr u_cycle_ctr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (ctr_load),
    .dec_i      (ctr_dec),
    .load_val_i (cyc_init_val),
    .zero_o     (ctr_zero)
  );

`ifdef TRACE_REPLAY_DEBUG_EN
  logic finish_pend_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      finish_pend_q <= 1'b0;
    end else if (active && (opcode == OP_FINISH)) begin
      finish_pend_q <= 1'b1;
    end
  end

  always @(posedge clk_i) begin
    if (v_o && yumi_i)
      $display("trace_replay_node: SEND addr=%0d payload=%0h", addr_q, payload);
    if (ready_o && v_i) begin
      $display("trace_replay_node: RECV addr=%0d payload=%0h", addr_q, payload);
      if (data_i != payload)
        $error("trace_replay_node: addr=%0d expected %0h actual %0h", addr_q, payload, data_i);
    end
    if (active && (opcode > OP_CYC_WAIT))
      $error("trace_replay_node: illegal opcode %0d at addr=%0d", opcode, addr_q);
    if (finish_pend_q)
      $finish;
  end
`else
  // FINISH retires exactly like DONE in synthesizable builds.
`endif

endmodule
`default_nettype wire

// File: tb/tb_trace_replay_node.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_replay_node
// Function : Randomized lockstep bench for trace_replay_node against a trace model.
// Revision : 1.0
// ============================================================================
module tb_trace_replay_node;

  localparam int W  = 8;
  localparam int AW = 6;
  localparam int ROM_DEPTH = 1 << AW;

  logic          clk_i   = 1'b0;
  logic          reset_i = 1'b0;
  logic          en_i    = 1'b0;
  logic          v_i     = 1'b0;
  logic          yumi_i  = 1'b0;
  logic [W-1:0]  data_i  = '0;
  logic          ready_o, v_o, done_o, error_o;
  logic [W-1:0]  data_o;
  logic [AW-1:0] rom_addr_o;
  logic [W+3:0]  rom_data_i;

  logic [W+3:0]  rom [ROM_DEPTH];

  assign rom_data_i = rom[rom_addr_o];

  always #5 clk_i = ~clk_i;

  trace_replay_node #(
    .ring_width_p     (W),
    .rom_addr_width_p (AW)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en_i       (en_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .yumi_i     (yumi_i),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .done_o     (done_o),
    .error_o    (error_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Trace model state: program counter, wait counter, sticky flags.
  int          m_pc;
  logic [31:0] m_cnt;
  bit          m_done, m_err;
  int          hold;
  int          cyc, first_wait, first_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_cnt = 0; m_done = 0; m_err = 0; hold = 0;
  endtask

  task automatic model_step();
    logic [3:0]   op;
    logic [W-1:0] pl;
    int           nxt;
    op  = rom[m_pc][W+3:W];
    pl  = rom[m_pc][W-1:0];
    nxt = m_pc;
    if (en_i && !m_done) begin
      case (op)
        4'd0: nxt = m_pc + 1;
        4'd1: begin hold++; if (yumi_i) nxt = m_pc + 1; end
        4'd2: if (v_i) begin if (data_i !== pl) m_err = 1; nxt = m_pc + 1; end
        4'd3, 4'd4: m_done = 1;
        4'd5: begin m_cnt = 32'(pl); nxt = m_pc + 1; end
        4'd6: if (m_cnt == 0) nxt = m_pc + 1; else m_cnt = m_cnt - 1;
        default: begin m_err = 1; nxt = m_pc + 1; end
      endcase
    end
    if (nxt != m_pc) hold = 0;
    m_pc = nxt % ROM_DEPTH;
  endtask

  function automatic logic [W+3:0] ent(input int op, input int pl);
    return {4'(op), W'(pl)};
  endfunction

  task automatic fill_rom(input int op);
    for (int i = 0; i < ROM_DEPTH; i++) rom[i] = ent(op, 0);
  endtask

  // Hold reset across one edge, check the reset state, release aligned at posedge+1.
  task automatic do_reset();
    reset_i = 1'b0; en_i = 1'b1; yumi_i = 1'b0; v_i = 1'b0;
    #1;
    chk("rst_addr", rom_addr_o, 0);
    chk("rst_v", v_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", error_o, 0);
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    model_reset();
    cyc = 0; first_wait = -1; first_v = -1;
  endtask

  // yumi_wait<0 selects random yumi/v_i; otherwise yumi after hold cycles of v_o.
  task automatic run(input int ncyc, input int yumi_wait, input int en_pct, input int bad_pct,
                     input int en_lo_a, input int en_lo_b, input int rst_pc);
    logic [3:0]   op;
    logic [W-1:0] pl;
    bit           exp_v, exp_r, did_rst;
    did_rst = 0;
    for (int c = 0; c < ncyc; c++) begin
      en_i  = (c >= en_lo_a && c < en_lo_b) ? 1'b0 : ($urandom_range(0, 99) < en_pct);
      op    = rom[m_pc][W+3:W];
      pl    = rom[m_pc][W-1:0];
      exp_v = en_i && !m_done && (op == 4'd1);
      exp_r = en_i && !m_done && (op == 4'd2);
      if (yumi_wait < 0) begin
        yumi_i = exp_v && ($urandom_range(0, 3) == 0);
        v_i    = ($urandom_range(0, 1) == 1);
      end else begin
        yumi_i = exp_v && (hold >= yumi_wait);
        v_i    = exp_r;
      end
      data_i = ($urandom_range(0, 99) < bad_pct) ? (pl ^ W'(1)) : pl;
      if (exp_r && !did_rst && rst_pc >= 0 && m_pc == rst_pc) begin
        #2 reset_i = 1'b0;
        #1;
        chk("async_rst_addr", rom_addr_o, 0);
        chk("async_rst_done", done_o, 0);
        chk("async_rst_err", error_o, 0);
        chk("async_rst_ready", ready_o, 0);
        model_reset();
        #1 reset_i = 1'b1;
        did_rst = 1;
        @(posedge clk_i);
        model_step();
        cyc++;
        #1;
        continue;
      end
      @(negedge clk_i);
      if (first_wait < 0 && rom[m_pc][W+3:W] == 4'd6) first_wait = cyc;
      if (first_v < 0 && v_o) first_v = cyc;
      chk("addr", rom_addr_o, m_pc);
      chk("v_o", v_o, exp_v);
      chk("ready_o", ready_o, exp_r);
      chk("data_o", data_o, exp_v ? pl : '0);
      chk("done_o", done_o, m_done);
      chk("error_o", error_o, m_err);
      @(posedge clk_i);
      model_step();
      cyc++;
      #1;
    end
  endtask

  task automatic random_rom(input bit with_done);
    int r;
    for (int i = 0; i < ROM_DEPTH; i++) begin
      r = $urandom_range(0, 99);
      if (r < 25)      rom[i] = ent(1, $urandom_range(0, 255));
      else if (r < 50) rom[i] = ent(2, $urandom_range(0, 255));
      else if (r < 60) rom[i] = ent(0, $urandom_range(0, 255));
      else if (r < 68) rom[i] = ent(5, $urandom_range(0, 7));
      else if (r < 76) rom[i] = ent(6, 0);
      else if (r < 88) rom[i] = ent($urandom_range(7, 15), 0);
      else             rom[i] = ent(0, 0);
    end
    if (with_done) rom[40] = ent($urandom_range(3, 4), 0);
  endtask

  initial begin
    @(posedge clk_i); #1;

    // Basic send/receive with matching result.
    fill_rom(3);
    rom[0] = ent(1, 'hA5); rom[1] = ent(2, 'h3C); rom[2] = ent(3, 0);
    do_reset();
    run(12, 2, 100, 0, -1, -1, -1);
    chk("t1_done", done_o, 1);
    chk("t1_err", error_o, 0);
    chk("t1_addr", rom_addr_o, 2);

    // Same trace, DUT returns the wrong value.
    do_reset();
    run(12, 2, 100, 100, -1, -1, -1);
    chk("t2_err", error_o, 1);
    chk("t2_done", done_o, 1);

    // Timed wait before a send.
    fill_rom(3);
    rom[0] = ent(5, 5); rom[1] = ent(6, 0); rom[2] = ent(1, 'h11); rom[3] = ent(3, 0);
    do_reset();
    run(16, 1, 100, 0, -1, -1, -1);
    chk("t3_wait_latency", first_v - first_wait, 6);
    chk("t3_done", done_o, 1);
    chk("t3_addr", rom_addr_o, 3);

    // Enable dropped for 4 cycles mid-SEND.
    fill_rom(3);
    rom[0] = ent(0, 0); rom[1] = ent(1, 'h5A); rom[2] = ent(3, 0);
    do_reset();
    run(16, 3, 100, 0, 2, 6, -1);
    chk("t4_done", done_o, 1);
    chk("t4_addr", rom_addr_o, 2);

    // Illegal opcode then DONE.
    fill_rom(3);
    rom[0] = ent(9, 0); rom[1] = ent(3, 0);
    do_reset();
    run(6, 1, 100, 0, -1, -1, -1);
    chk("t5_err", error_o, 1);
    chk("t5_done", done_o, 1);
    chk("t5_addr", rom_addr_o, 1);

    // Reset asserted mid-RECV, trace replays from the start.
    fill_rom(3);
    rom[0] = ent(9, 0); rom[1] = ent(1, 'hA5); rom[2] = ent(2, 'h3C); rom[3] = ent(3, 0);
    do_reset();
    run(20, 1, 100, 0, -1, -1, 2);
    chk("t6_done", done_o, 1);
    chk("t6_addr", rom_addr_o, 3);

    // Randomized traces: wrapping without DONE, and with a DONE/FINISH terminator.
    for (int s = 0; s < 3; s++) begin
      random_rom(1'b0);
      do_reset();
      run(1500, -1, 80, 30, -1, -1, -1);
    end
    random_rom(1'b1);
    do_reset();
    run(1500, -1, 85, 30, -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trace_replay_node.md
Name: trace_replay_node

Overview:
- Synthesizable trace-driven stimulus/checker node for block-level benches.
- Fetches 4-bit-opcode commands from an external combinational ROM and sends payloads to a DUT over a valid/yumi channel.
- Accepts DUT results over a valid/ready channel and compares them against expected payloads.
- Flags completion and mismatches; typically clocked on the inverted bench clock.

Parameters:
- ring_width_p, 80: payload width in bits, for both send and receive.
- rom_addr_width_p, 6: ROM address width.
- Derived: rom entry width = ring_width_p+4; opcode = rom_data_i[ring_width_p+3:ring_width_p]; payload = rom_data_i[ring_width_p-1:0].

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- en_i  in  1  global enable; low = freeze (no fetch, no handshakes).
- v_i  in  1  DUT result valid.
- data_i  in  ring_width_p  DUT result data.
- ready_o  out  1  node can accept a result.
- v_o  out  1  stimulus valid.
- data_o  out  ring_width_p  stimulus payload.
- yumi_i  in  1  consumer takes stimulus this cycle; legal only when v_o=1.
- rom_addr_o  out  rom_addr_width_p  current command address.
- rom_data_i  in  ring_width_p+4  command at rom_addr_o, combinational.
- done_o  out  1  trace finished, sticky.
- error_o  out  1  mismatch or illegal opcode seen, sticky.

Behaviour:
- Reset (reset_i=0, async): address counter=0, cycle counter=0, done_o=0, error_o=0, v_o=0, ready_o=0.
- Single address register drives rom_addr_o; the command executes in the same cycle it is addressed (zero-latency ROM).
- Opcodes:
  - 0 NOP: advance next cycle.
  - 1 SEND: v_o=1, data_o=payload; advance on the clock edge where yumi_i=1; otherwise hold with v_o stable.
  - 2 RECV: ready_o=1; on v_i&ready_o, compare data_i with payload, set error_o on mismatch, advance.
  - 3 DONE: set done_o; address stops; v_o=ready_o=0 forever after, until reset.
  - 4 FINISH: same as DONE (see Optional Feature).
  - 5 CYC_INIT: load cycle counter with payload[31:0] (zero-extended if ring_width_p<32); advance.
  - 6 CYC_WAIT: hold while counter≠0, decrementing by 1 per cycle; advance when counter==0.
  - 7–15: illegal; set error_o, then advance.
- v_o and ready_o are never both 1; data_o = payload when v_o=1, otherwise 0.
- en_i=0: v_o=0, ready_o=0, no advance, counter holds, yumi_i/v_i ignored; resumes at the same command.
- error_o does not stop replay; both flags are sticky until reset.
- Address wraps modulo 2^rom_addr_width_p when no DONE is present.
- Reset mid-SEND/RECV: the transfer is abandoned; restart at address 0.
- No combinational path from yumi_i or v_i to v_o or ready_o.

Optional Feature:
- Macro TRACE_REPLAY_DEBUG_EN.
- Defined: non-synthesizable $display on every SEND/RECV with address and payload; $error with expected/actual on mismatch or illegal opcode; FINISH calls $finish one cycle after done_o rises.
- Undefined: no prints; FINISH behaves exactly as DONE; fully synthesizable.

Decomposition:
- Package trace_replay_pkg: opcode width constant (4) and enum of opcodes (NOP, SEND, RECV, DONE, FINISH, CYC_INIT, CYC_WAIT).
- One sub-module, trace_replay_cycle_ctr: a 32-bit loadable down-counter with a zero flag, used by CYC_INIT/CYC_WAIT.

Test Plan:
- ring_width_p=8. ROM {SEND 0xA5, RECV 0x3C, DONE}. Consumer yumis 2 cycles after v_o; DUT returns 0x3C. Required: data_o=0xA5 held stable until yumi; ready_o rises after yumi; done_o=1; error_o=0; rom_addr_o stays 2.
- Same ROM, DUT returns 0x3D. Required: error_o=1 and sticky; done_o=1 afterwards.
- ROM {CYC_INIT 5, CYC_WAIT, SEND 0x11, DONE}. Required: v_o rises exactly 6 cycles after CYC_WAIT is first addressed (5 decrement cycles, then advance on the sixth edge); yumi completes the SEND.
- Drop en_i for 4 cycles during SEND with yumi_i held 0. Required: v_o=0 for those cycles; rom_addr_o unchanged; SEND completes after en_i returns.
- Opcode 9 at address 0, then DONE. Required: error_o=1; advance to address 1; done_o=1.
- Assert reset mid-RECV. Required: rom_addr_o=0, done_o=0, error_o=0 immediately, asynchronously; trace replays from the start.
